// File: rtl/comparator_8b.sv
// Registered magnitude comparator, unsigned or two's-complement per transaction.
// Flags are one-hot and appear one cycle after in_valid.
module comparator_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             A_greater_B,
  output logic             A_equal_B,
  output logic             A_less_B
);

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic             gt;
  logic             eq;
  logic             lt;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    a_m = A;
    b_m = B;
    a_m[WIDTH-1] = A[WIDTH-1] ^ signed_mode;
    b_m[WIDTH-1] = B[WIDTH-1] ^ signed_mode;
  end

  always_comb begin
    gt = 1'b0;
    eq = 1'b1;
    lt = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      gt = gt | (eq & a_m[i] & ~b_m[i]);
      lt = lt | (eq & ~a_m[i] & b_m[i]);
      eq = eq & ~(a_m[i] ^ b_m[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      A_greater_B <= 1'b0;
      A_equal_B   <= 1'b0;
      A_less_B    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        A_greater_B <= gt;
        A_equal_B   <= eq;
        A_less_B    <= lt;
      end
    end
  end

endmodule

// File: tb/tb_comparator_8b.sv
// Directed and random checks of comparator_8b against a $signed reference
// model, with expected flags queued at drive time and popped at output.
module tb_comparator_8b;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       out_valid;
  logic       A_greater_B;
  logic       A_equal_B;
  logic       A_less_B;

  int n_assert = 0;
  int n_fail = 0;
  logic [2:0] sb[$];
  logic [2:0] last = 3'b000;

  comparator_8b #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .signed_mode(signed_mode),
    .A(A),
    .B(B),
    .out_valid(out_valid),
    .A_greater_B(A_greater_B),
    .A_equal_B(A_equal_B),
    .A_less_B(A_less_B)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model(input logic s,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    logic g;
    logic l;
    if (s) begin
      g = $signed(a) > $signed(b);
      l = $signed(a) < $signed(b);
    end else begin
      g = a > b;
      l = a < b;
    end
    return {g, a == b, l};
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs,
                     input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic s, input logic [7:0] a,
                       input logic [7:0] b);
    logic [2:0] flags;
    logic [2:0] exp;
    rst = r;
    in_valid = v;
    signed_mode = s;
    A = a;
    B = b;
    if (v && !r) sb.push_back(model(s, a, b));
    @(posedge clk);
    #1;
    flags = {A_greater_B, A_equal_B, A_less_B};
    chk({tag, ".valid"}, {2'b00, out_valid}, {2'b00, v && !r});
    if (r) begin
      sb.delete();
      last = 3'b000;
      chk({tag, ".rst"}, flags, 3'b000);
    end else if (v) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s.queue observed=empty expected=entry", tag);
      end else begin
        exp = sb.pop_front();
        last = exp;
        chk({tag, ".flags"}, flags, exp);
        chk({tag, ".onehot"}, {2'b00, $onehot(flags)}, 3'b001);
      end
    end else begin
      chk({tag, ".hold"}, flags, last);
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    @(negedge clk);
    cycle("rst0", 1, 0, 0, 8'h00, 8'h00);
    cycle("rst1", 1, 0, 0, 8'h00, 8'h00);
    cycle("idle", 0, 0, 0, 8'h00, 8'h00);
    chk("idle.exact", {A_greater_B, A_equal_B, A_less_B}, 3'b000);
    cycle("u00_01", 0, 1, 0, 8'h00, 8'h01);
    chk("u00_01.lt", {A_greater_B, A_equal_B, A_less_B}, 3'b001);
    cycle("uFF_7F", 0, 1, 0, 8'hFF, 8'h7F);
    chk("uFF_7F.gt", {A_greater_B, A_equal_B, A_less_B}, 3'b100);
    cycle("sFF_7F", 0, 1, 1, 8'hFF, 8'h7F);
    chk("sFF_7F.lt", {A_greater_B, A_equal_B, A_less_B}, 3'b001);
    cycle("u5A", 0, 1, 0, 8'h5A, 8'h5A);
    cycle("s5A", 0, 1, 1, 8'h5A, 8'h5A);
    chk("s5A.eq", {A_greater_B, A_equal_B, A_less_B}, 3'b010);
    cycle("s80_00", 0, 1, 1, 8'h80, 8'h00);
    chk("s80_00.lt", {A_greater_B, A_equal_B, A_less_B}, 3'b001);
    cycle("s00_80", 0, 1, 1, 8'h00, 8'h80);
    chk("s00_80.gt", {A_greater_B, A_equal_B, A_less_B}, 3'b100);
    cycle("uFE_FF", 0, 1, 0, 8'hFE, 8'hFF);
    cycle("drop", 0, 0, 0, 8'h12, 8'h34);
    chk("drop.lt", {A_greater_B, A_equal_B, A_less_B}, 3'b001);
    cycle("rstv", 1, 1, 0, 8'h09, 8'h03);
    chk("rstv.zero", {out_valid, A_greater_B, A_equal_B}, 3'b000);
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = (i % 7 == 0) ? ra : 8'($urandom);
      rs = 1'($urandom);
      cycle("rand", 0, 1, rs, ra, rb);
      if (i % 13 == 12) cycle("rgap", 0, 0, 0, 8'h00, 8'h00);
    end
    cycle("tail", 0, 0, 0, 8'h00, 8'h00);
    chk("sb.empty", {2'b00, sb.size() == 0}, 3'b001);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
